i2c_target_regfile: RTL and testbench

I2C target (slave) that sits directly downstream of the I2C master on the SCL/SDA bus. It consumes the master's write transaction: 7-bit address, register-pointer byte, then data bytes. It also serves reads from an internal byte register file. Bus pins are oversampled on the system clock and SDA is driven open-drain. A write strobe exports each accepted byte to surrounding logic.

---
 rtl/i2c_pkg.sv | 27 ++
 rtl/i2c_bus_sync.sv | 59 +++++
 rtl/i2c_target_regfile.sv | 205 ++++++++++++++++++++
 tb/tb_i2c_target_regfile.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared I2C definitions: target FSM state encoding, ACK/NACK bit levels and
// the 7-bit address width used by both the target and the master.
// -----------------------------------------------------------------------------
package i2c_pkg;

    localparam int ADDR_W = 7;

    // Bit level on SDA during the acknowledge slot
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ACK_ADDR,
        REG,
        ACK_REG,
        WDATA,
        ACK_WDATA,
        RDATA,
        MACK,
        IGNORE
    } state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// -----------------------------------------------------------------------------
// i2c_bus_sync
// Brings raw SCL/SDA pin levels into the clk domain (2-flop synchronizer plus
// one history flop each) and derives bus events from the synchronized values.
// An event is visible to downstream logic 3 clk after the pin changes.
//
// Ports:
//   clk, rst   system clock, asynchronous active-high reset (flops preset to 1)
//   scl_i      raw SCL pin
//   sda_i      raw SDA pin
//   scl_rise   one-clk pulse on SCL 0->1
//   scl_fall   one-clk pulse on SCL 1->0
//   start_det  one-clk pulse on SDA fall while SCL high
//   stop_det   one-clk pulse on SDA rise while SCL high
//   sda_s      synchronized SDA level
// -----------------------------------------------------------------------------
module i2c_bus_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic scl_s1, scl_s2, scl_h;
    logic sda_s1, sda_s2, sda_h;

    // Preset to 1 (idle bus level) so releasing reset never fakes an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_h  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_h  <= 1'b1;
        end else begin
            scl_s1 <= scl_i;
            scl_s2 <= scl_s1;
            scl_h  <= scl_s2;
            sda_s1 <= sda_i;
            sda_s2 <= sda_s1;
            sda_h  <= sda_s2;
        end
    end

    assign scl_rise  = scl_s2 & ~scl_h;
    assign scl_fall  = ~scl_s2 & scl_h;
    // SCL must be high in both samples so an SDA change next to an SCL edge
    // is never mistaken for START/STOP
    assign start_det = scl_s2 & scl_h & sda_h & ~sda_s2;
    assign stop_det  = scl_s2 & scl_h & ~sda_h & sda_s2;
    assign sda_s     = sda_s2;

endmodule

// File: rtl/i2c_target_regfile.sv
// -----------------------------------------------------------------------------
// i2c_target_regfile
// I2C target with a byte-wide register file. A write transaction is
// device address, register pointer, then data bytes (auto-incrementing,
// wrapping at REG_DEPTH). A read returns bytes from the current pointer until
// the master NACKs. SDA is driven open-drain; SCL is never stretched.
//
// Ports:
//   clk, rst   system clock (>= 8x SCL), asynchronous active-high reset
//   scl_i      raw SCL pin level
//   sda_i      raw SDA pin level
//   sda_oe     1 = pull SDA low, 0 = release
//   wr_strobe  one-clk pulse per accepted data byte
//   wr_addr    register index of the current/last write
//   wr_data    byte written, held after the strobe
//   busy       high from START until STOP
// -----------------------------------------------------------------------------
module i2c_target_regfile
    import i2c_pkg::*;
#(
    parameter logic [ADDR_W-1:0] DEV_ADDR  = 7'd105,
    parameter int                REG_DEPTH = 64,
    parameter logic [7:0]        RESET_VAL = 8'h00,
    localparam int               AW        = $clog2(REG_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    output logic          wr_strobe,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          busy
);

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_bus_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    state_t        state, state_next;
    logic [3:0]    bit_cnt, cnt_next;
    logic [7:0]    shift, shift_next;
    logic          rw, rw_next;
    logic [AW-1:0] pointer, ptr_next;
    logic          oe_next, busy_next, mem_we;
    logic [7:0]    mem [REG_DEPTH];
    logic [7:0]    rd_byte;

    assign rd_byte = mem[pointer];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            rw        <= 1'b0;
            pointer   <= '0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            for (int i = 0; i < REG_DEPTH; i++) mem[i] <= RESET_VAL;
        end else begin
            state     <= state_next;
            bit_cnt   <= cnt_next;
            shift     <= shift_next;
            rw        <= rw_next;
            pointer   <= ptr_next;
            sda_oe    <= oe_next;
            busy      <= busy_next;
            wr_strobe <= mem_we;
            if (mem_we) begin
                mem[pointer] <= shift;
                wr_addr      <= pointer;
                wr_data      <= shift;
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = bit_cnt;
        shift_next = shift;
        rw_next    = rw;
        ptr_next   = pointer;
        oe_next    = sda_oe;
        busy_next  = busy;
        mem_we     = 1'b0;

        // Bus conditions override any SCL edge seen in the same clk
        if (start_det) begin
            state_next = ADDR;
            cnt_next   = '0;
            oe_next    = 1'b0;
            busy_next  = 1'b1;
        end else if (stop_det) begin
            state_next = IDLE;
            oe_next    = 1'b0;
            busy_next  = 1'b0;
        end else begin
            case (state)
                ADDR, REG, WDATA: begin
                    // bit_cnt counts rising edges; the falling edge that
                    // follows the 8th one opens the ACK slot. The falling
                    // edge right after START arrives with bit_cnt == 0.
                    if (scl_rise) begin
                        shift_next = {shift[6:0], sda_s};
                        cnt_next   = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        cnt_next = '0;
                        if (state == ADDR) begin
                            if (shift[7:1] == DEV_ADDR) begin
                                rw_next    = shift[0];
                                oe_next    = 1'b1;
                                state_next = ACK_ADDR;
                            end else begin
                                state_next = IGNORE;
                            end
                        end else if (state == REG) begin
                            if (int'(shift) < REG_DEPTH) begin
                                ptr_next   = shift[AW-1:0];
                                oe_next    = 1'b1;
                                state_next = ACK_REG;
                            end else begin
                                state_next = IGNORE;
                            end
                        end else begin
                            mem_we     = 1'b1;
                            ptr_next   = pointer + 1'b1;
                            oe_next    = 1'b1;
                            state_next = ACK_WDATA;
                        end
                    end
                end
                ACK_ADDR: begin
                    if (scl_fall) begin
                        cnt_next = '0;
                        if (rw) begin
                            // Read: first data bit goes out in the same
                            // low phase that ends our ACK
                            shift_next = rd_byte;
                            oe_next    = ~rd_byte[7];
                            state_next = RDATA;
                        end else begin
                            oe_next    = 1'b0;
                            state_next = REG;
                        end
                    end
                end
                ACK_REG, ACK_WDATA: begin
                    if (scl_fall) begin
                        oe_next    = 1'b0;
                        cnt_next   = '0;
                        state_next = WDATA;
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        cnt_next = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            oe_next    = 1'b0;
                            cnt_next   = '0;
                            state_next = MACK;
                        end else begin
                            oe_next    = ~shift[6];
                            shift_next = {shift[6:0], 1'b0};
                        end
                    end
                end
                MACK: begin
                    // bit_cnt == 1 marks "master ACKed, reload on fall"
                    if (scl_rise) begin
                        if (sda_s == NACK) begin
                            state_next = IGNORE;
                        end else begin
                            ptr_next = pointer + 1'b1;
                            cnt_next = 4'd1;
                        end
                    end else if (scl_fall && bit_cnt == 4'd1) begin
                        shift_next = rd_byte;
                        oe_next    = ~rd_byte[7];
                        cnt_next   = '0;
                        state_next = RDATA;
                    end
                end
                IGNORE: oe_next = 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target_regfile.sv
module tb_i2c_target_regfile;

    localparam int Q = 5;   // clk cycles per quarter SCL period

    typedef struct packed {
        logic [5:0] a;
        logic [7:0] d;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m, sda_m;
    logic       sda_bus;
    logic       sda_oe, wr_strobe, busy;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;

    int  checks = 0;
    int  errors = 0;
    int  oe_cnt = 0;
    wr_t exp_q[$];

    assign sda_bus = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_regfile #(
        .DEV_ADDR  (7'd105),
        .REG_DEPTH (64),
        .RESET_VAL (8'h00)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_m),
        .sda_i     (sda_bus),
        .sda_oe    (sda_oe),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    always @(posedge clk) if (sda_oe) oe_cnt++;

    // Write-strobe monitor: every strobe must match the oldest expected write
    always @(negedge clk) begin : strobe_mon
        wr_t e;
        if (!rst && wr_strobe) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got addr %0d data 0x%02h, required no strobe", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    errors++;
                    $display("FAIL strobe: got addr %0d data 0x%02h, required addr %0d data 0x%02h",
                             wr_addr, wr_data, e.a, e.d);
                end
            end
        end
    end

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Works from idle (SCL high) and as a repeated START (SCL low)
    task automatic i2c_start();
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(Q);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    wait_clk(Q);
        scl_m = 1'b1; wait_clk(2 * Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        b = sda_bus;  wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
        recv_bit(ack);
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] v);
        for (int i = 7; i >= 0; i--) recv_bit(v[i]);
        send_bit(mack);
    endtask

    task automatic write_seq(input string name, input logic [7:0] r,
                             input logic [7:0] d0, input logic [7:0] d1, input int n);
        logic ack;
        logic [5:0] a;
        i2c_start();
        chk({name, "_busy"}, busy, 1);
        send_byte(8'hD2, ack); chk({name, "_ack_addr"}, ack, 0);
        send_byte(r, ack);     chk({name, "_ack_reg"}, ack, 0);
        a = r[5:0];
        exp_q.push_back('{a: a, d: d0});
        send_byte(d0, ack);    chk({name, "_ack_d0"}, ack, 0);
        if (n > 1) begin
            a = a + 6'd1;
            exp_q.push_back('{a: a, d: d1});
            send_byte(d1, ack); chk({name, "_ack_d1"}, ack, 0);
        end
        i2c_stop();
        wait_clk(2);
        chk({name, "_busy_after_stop"}, busy, 0);
    endtask

    task automatic read_seq(input string name, input logic [7:0] r,
                            input logic [7:0] e0, input logic [7:0] e1, input int n);
        logic ack;
        logic [7:0] v;
        i2c_start();
        send_byte(8'hD2, ack); chk({name, "_ack_addr_w"}, ack, 0);
        send_byte(r, ack);     chk({name, "_ack_reg"}, ack, 0);
        i2c_start();
        send_byte(8'hD3, ack); chk({name, "_ack_addr_r"}, ack, 0);
        recv_byte((n > 1) ? 1'b0 : 1'b1, v);
        chk({name, "_byte0"}, v, e0);
        if (n > 1) begin
            recv_byte(1'b1, v);
            chk({name, "_byte1"}, v, e1);
        end
        wait_clk(2);
        chk({name, "_released_after_nack"}, sda_oe, 0);
        chk({name, "_busy_before_stop"}, busy, 1);
        i2c_stop();
        wait_clk(2);
        chk({name, "_busy_after_stop"}, busy, 0);
    endtask

    initial begin
        logic ack;
        int   oe0;
        rst   = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(4);

        // Reset state
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_strobe", wr_strobe, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);

        // 1: reset asserted in the middle of the address byte
        i2c_start();
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        chk("t1_busy_mid_addr", busy, 1);
        #3 rst = 1'b1;
        #1;
        chk("t1_busy_async_rst", busy, 0);
        chk("t1_oe_async_rst", sda_oe, 0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(4);
        read_seq("t1_read", 8'h25, 8'h00, 8'h00, 1);

        // 2: single-byte write
        write_seq("t2_write", 8'h25, 8'hA5, 8'h00, 1);

        // 3: read it back with a repeated START
        read_seq("t3_read", 8'h25, 8'hA5, 8'h00, 1);

        // 4: wrong device address never gets an ACK
        oe0 = oe_cnt;
        i2c_start();
        send_byte(8'hA0, ack); chk("t4_nack_addr", ack, 1);
        send_byte(8'h55, ack); chk("t4_nack_data", ack, 1);
        i2c_stop();
        wait_clk(2);
        chk("t4_oe_never", oe_cnt - oe0, 0);
        chk("t4_busy_after_stop", busy, 0);

        // 5: burst across the top of the register file
        write_seq("t5_write", 8'h3F, 8'h11, 8'h22, 2);
        read_seq("t5_read", 8'h3F, 8'h11, 8'h22, 2);

        // 6: out-of-range register pointer
        i2c_start();
        send_byte(8'hD2, ack); chk("t6_ack_addr", ack, 0);
        send_byte(8'h40, ack); chk("t6_nack_reg", ack, 1);
        send_byte(8'h77, ack); chk("t6_nack_d0", ack, 1);
        send_byte(8'h88, ack); chk("t6_nack_d1", ack, 1);
        i2c_stop();
        wait_clk(2);
        chk("t6_busy_after_stop", busy, 0);
        read_seq("t6_read_r0", 8'h00, 8'h22, 8'h00, 1);

        wait_clk(20);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
